pipe_hazard_ctrl: RTL and testbench

//  Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_hazard_ctrl_pkg.sv | 32 +++
 rtl/pipe_hazard_ctrl_if.sv | 34 +++
 rtl/pipe_hazard_ctrl_sat_counter.sv | 21 ++
 rtl/pipe_hazard_ctrl.sv | 106 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared types and constants for the pipeline hazard sequencer
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_flush;
    logic ex_mem_write;
    logic mem_wb_bubble;
  } hz_ctrl_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam hz_ctrl_t CTRL_RUN    = hz_ctrl_t'(7'b1101010);
  localparam hz_ctrl_t CTRL_FREEZE = hz_ctrl_t'(7'b0000001);
  localparam hz_ctrl_t CTRL_RESET  = hz_ctrl_t'(7'b0010101);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency
  function automatic logic load_use_hazard(input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic memread, input logic [4:0] rd);
    return memread && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - datapath-facing bundle between pipeline and hazard sequencer
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             ex_memread;
  logic [4:0]       ex_rd;
  logic             ex_redirect;
  logic             mem_access;
  logic             dmem_ready;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_write;
  logic             id_ex_flush;
  logic             ex_mem_write;
  logic             mem_wb_bubble;
  logic             mem_timeout_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, ex_memread, ex_rd, ex_redirect, mem_access, dmem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write,
           mem_wb_bubble, mem_timeout_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, ex_memread, ex_rd, ex_redirect, mem_access, dmem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write,
           mem_wb_bubble, mem_timeout_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// rtl/pipe_hazard_ctrl_sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (clear_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - per-cycle load/hold/bubble sequencer for the 5-stage pipeline registers
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input logic               clk,
  input logic               reset,
  pipe_hazard_ctrl_if.slave hz
);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT);

  localparam logic [1:0] ST_RUN      = RUN;
  localparam logic [1:0] ST_MEM_WAIT = MEM_WAIT;
  localparam logic [1:0] ST_ERROR    = ERROR;

  logic [1:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  hz_ctrl_t          ctrl;
  logic              load_use;
  logic              redirect_apply;
  logic              stall_inc;

  assign load_use = load_use_hazard(hz.id_rs1, hz.id_rs2, hz.ex_memread, hz.ex_rd);

  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    ctrl           = CTRL_RUN;
    redirect_apply = 1'b0;
    if (!reset) begin
      ctrl    = CTRL_RESET;
      state_d = ST_RUN;
      wait_d  = '0;
    end else begin
      case (state_q)
        ST_RUN, ST_MEM_WAIT: begin
          if (((state_q == ST_MEM_WAIT) || hz.mem_access) && !hz.dmem_ready) begin
            ctrl = CTRL_FREEZE;
            if (state_q == ST_RUN) begin
              state_d = ST_MEM_WAIT;
              wait_d  = WAIT_W'(1);
            end else if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
              state_d = ST_ERROR;
            end else begin
              wait_d = wait_q + 1'b1;
            end
          end else begin
            // Exit cycle behaves as RUN, so a redirect held by the frozen EX stage lands here
            state_d = ST_RUN;
            wait_d  = '0;
            if (hz.ex_redirect) begin
              ctrl.if_id_flush = 1'b1;
              ctrl.id_ex_flush = 1'b1;
              redirect_apply   = 1'b1;
            end else if (load_use) begin
              ctrl.pc_write    = 1'b0;
              ctrl.if_id_write = 1'b0;
              ctrl.id_ex_flush = 1'b1;
            end
          end
        end
        default: begin
          ctrl    = CTRL_FREEZE;
          state_d = ST_ERROR;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign stall_inc = reset && !ctrl.pc_write;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .clear_i (!reset),
    .inc_i   (stall_inc),
    .count_o (hz.stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .clear_i (!reset),
    .inc_i   (redirect_apply),
    .count_o (hz.flush_cnt)
  );

  assign hz.pc_write        = ctrl.pc_write;
  assign hz.if_id_write     = ctrl.if_id_write;
  assign hz.if_id_flush     = ctrl.if_id_flush;
  assign hz.id_ex_write     = ctrl.id_ex_write;
  assign hz.id_ex_flush     = ctrl.id_ex_flush;
  assign hz.ex_mem_write    = ctrl.ex_mem_write;
  assign hz.mem_wb_bubble   = ctrl.mem_wb_bubble;
  assign hz.mem_timeout_err = (state_q == ST_ERROR);
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - randomized and directed bench against a behavioural hazard model
module tb_pipe_hazard_ctrl;
  localparam int MEM_TIMEOUT = 16;
  localparam int CNT_W       = 5;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  // model: consecutive frozen cycles, sticky error, counters
  int   m_pending;
  bit   m_err;
  int   m_stall;
  int   m_flush;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle(input logic [4:0] rs1, input logic [4:0] rs2, input logic mr,
                       input logic [4:0] rd, input logic redir, input logic acc,
                       input logic rdy, input logic rst);
    logic [6:0] exp;
    logic [6:0] got;
    bit lu, frz;
    @(negedge clk);
    hz.id_rs1      = rs1;
    hz.id_rs2      = rs2;
    hz.ex_memread  = mr;
    hz.ex_rd       = rd;
    hz.ex_redirect = redir;
    hz.mem_access  = acc;
    hz.dmem_ready  = rdy;
    reset          = rst;
    #1;
    lu  = mr && (rd != 0) && ((rd == rs1) || (rd == rs2));
    frz = m_err || (((m_pending > 0) || acc) && !rdy);
    // bit order: pc, if_id_w, if_id_flush, id_ex_w, id_ex_flush, ex_mem_w, mem_wb_bubble
    if (!rst)       exp = 7'b0010101;
    else if (frz)   exp = 7'b0000001;
    else if (redir) exp = 7'b1111110;
    else if (lu)    exp = 7'b0001110;
    else            exp = 7'b1101010;
    got = {hz.pc_write, hz.if_id_write, hz.if_id_flush, hz.id_ex_write,
           hz.id_ex_flush, hz.ex_mem_write, hz.mem_wb_bubble};
    chk("ctrl", 32'(got), 32'(exp));
    chk("err", 32'(hz.mem_timeout_err), 32'(m_err));
    chk("stall_cnt", 32'(hz.stall_cnt), m_stall);
    chk("flush_cnt", 32'(hz.flush_cnt), m_flush);
    @(posedge clk);
    if (!rst) begin
      m_pending = 0;
      m_err     = 1'b0;
      m_stall   = 0;
      m_flush   = 0;
    end else begin
      if (!exp[6] && m_stall < CNT_MAX) m_stall++;
      if (!frz && redir && m_flush < CNT_MAX) m_flush++;
      if (!m_err) begin
        if (frz) begin
          m_pending++;
          if (m_pending == MEM_TIMEOUT) m_err = 1'b1;
        end else begin
          m_pending = 0;
        end
      end
    end
  endtask

  task automatic idle(input logic rst);
    cycle(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, rst);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    m_pending = 0;
    m_err     = 1'b0;
    m_stall   = 0;
    m_flush   = 0;
    reset     = 1'b0;
    hz.id_rs1 = '0; hz.id_rs2 = '0; hz.ex_memread = 1'b0; hz.ex_rd = '0;
    hz.ex_redirect = 1'b0; hz.mem_access = 1'b0; hz.dmem_ready = 1'b1;

    idle(1'b0);
    idle(1'b0);

    // load-use on rs2
    cycle(5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1'b1);
    #1 chk("t1_stall", 32'(hz.stall_cnt), 32'd1);

    // load to x0 never stalls
    idle(1'b0);
    cycle(5'd0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    #1 chk("t2_stall", 32'(hz.stall_cnt), 32'd0);

    // redirect overrides load-use
    idle(1'b0);
    cycle(5'd7, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1);
    #1 chk("t3_flush", 32'(hz.flush_cnt), 32'd1);
    chk("t3_stall", 32'(hz.stall_cnt), 32'd0);

    // three-cycle memory wait then release
    idle(1'b0);
    repeat (3) cycle(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    cycle(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    #1 chk("t4_stall", 32'(hz.stall_cnt), 32'd3);

    // timeout: 16 frozen cycles lead to a sticky error
    idle(1'b0);
    repeat (MEM_TIMEOUT - 1) cycle(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    #1 chk("t5_err_early", 32'(hz.mem_timeout_err), 32'd0);
    cycle(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    #1 chk("t5_err", 32'(hz.mem_timeout_err), 32'd1);
    repeat (3) idle(1'b1);
    #1 chk("t5_err_sticky", 32'(hz.mem_timeout_err), 32'd1);
    idle(1'b0);
    #1 chk("t5_err_clr", 32'(hz.mem_timeout_err), 32'd0);

    // reset mid-wait, then redirect held across a freeze lands on the exit cycle
    repeat (2) cycle(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(1'b0);
    idle(1'b1);
    #1 chk("t6_stall_clr", 32'(hz.stall_cnt), 32'd0);
    repeat (2) cycle(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    #1 chk("t6_flush_held", 32'(hz.flush_cnt), 32'd0);
    cycle(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1);
    #1 chk("t6_flush_exit", 32'(hz.flush_cnt), 32'd1);

    // randomized traffic, long enough to saturate the narrow counters
    for (int i = 0; i < 800; i++) begin
      cycle(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 99) < 15), 1'($urandom_range(0, 99) < 35),
            1'($urandom_range(0, 99) < 70), 1'($urandom_range(0, 199) >= 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1);
  end
endmodule
